// File: rtl/hrz_peak_scan.sv
// Frame peak scanner: snapshots all Goertzel bins on a rising all-valid edge, scans them one
// bin per cycle for the largest value and the threshold hit mask, then publishes a frame-counted result set.
module hrz_peak_scan #(
  parameter int NF = 11,
  parameter int DW = 32,
  parameter int CW = 16,
  parameter int IW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NF-1:0]    valid_i,
  input  logic [NF*DW-1:0] data_i,
  input  logic [DW-1:0]    thr_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IW-1:0]    peak_idx_o,
  output logic [DW-1:0]    peak_val_o,
  output logic [NF-1:0]    hit_mask_o,
  output logic [CW-1:0]    frame_cnt_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic          all_v, all_v_d, trig;
  logic [DW-1:0] snap [NF];
  logic [DW-1:0] thr_q, max_q, max_n, cur;
  logic [IW-1:0] idx_q, idx_n, bin;
  logic [NF-1:0] mask_q, mask_n;

  assign all_v = &valid_i;
  assign trig  = all_v & ~all_v_d;

  // Next scan values for the bin under the counter; the last bin publishes these directly.
  always_comb begin
    cur    = snap[bin];
    max_n  = max_q;
    idx_n  = idx_q;
    mask_n = mask_q;
    if (bin == '0 || cur > max_q) begin
      max_n = cur;
      idx_n = bin;
    end
    mask_n[bin] = (cur >= thr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      all_v_d     <= 1'b0;
      thr_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      bin         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      peak_idx_o  <= '0;
      peak_val_o  <= '0;
      hit_mask_o  <= '0;
      frame_cnt_o <= '0;
      ovf_o       <= 1'b0;
      for (int i = 0; i < NF; i++) snap[i] <= '0;
    end else begin
      all_v_d <= all_v;
      done_o  <= 1'b0;
      if (clr_i) begin
        state       <= IDLE;
        busy_o      <= 1'b0;
        peak_idx_o  <= '0;
        peak_val_o  <= '0;
        hit_mask_o  <= '0;
        frame_cnt_o <= '0;
        ovf_o       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              for (int i = 0; i < NF; i++) snap[i] <= data_i[i*DW +: DW];
              thr_q  <= thr_i;
              max_q  <= '0;
              idx_q  <= '0;
              mask_q <= '0;
              bin    <= '0;
              busy_o <= 1'b1;
              state  <= SCAN;
            end
          end
          SCAN: begin
            if (trig) ovf_o <= 1'b1;
            max_q  <= max_n;
            idx_q  <= idx_n;
            mask_q <= mask_n;
            if (bin == IW'(NF - 1)) begin
              state       <= DONE;
              done_o      <= 1'b1;
              peak_idx_o  <= idx_n;
              peak_val_o  <= max_n;
              hit_mask_o  <= mask_n;
              frame_cnt_o <= frame_cnt_o + CW'(1);
            end else begin
              bin <= bin + IW'(1);
            end
          end
          DONE: begin
            if (trig) ovf_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hrz_peak_scan.sv
// Bench for hrz_peak_scan: frame-level reference model checked every cycle,
// plus directed frames with hand-computed results and randomized traffic.
module tb_hrz_peak_scan;
  localparam int NF = 11;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NF-1:0]    valid_i = '0;
  logic [NF*DW-1:0] data_i = '0;
  logic [DW-1:0]    thr_i = '0;
  logic             clr_i = 1'b0;
  logic             busy_o, done_o, ovf_o;
  logic [IW-1:0]    peak_idx_o;
  logic [DW-1:0]    peak_val_o;
  logic [NF-1:0]    hit_mask_o;
  logic [CW-1:0]    frame_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  hrz_peak_scan #(.NF(NF), .DW(DW), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i), .thr_i(thr_i),
    .clr_i(clr_i), .busy_o(busy_o), .done_o(done_o), .peak_idx_o(peak_idx_o),
    .peak_val_o(peak_val_o), .hit_mask_o(hit_mask_o), .frame_cnt_o(frame_cnt_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: a frame's result is computed in full at its trigger,
  // then published NF edges later; the engine is busy until one cycle after publishing.
  logic          m_prev = 1'b0;
  int            m_left = 0;
  bit            m_in_done = 1'b0;
  bit            m_allv, m_trig, m_was_done;
  logic          e_done = 1'b0;
  logic [IW-1:0] e_idx = '0, p_idx;
  logic [DW-1:0] e_val = '0, p_val, m_v;
  logic [NF-1:0] e_mask = '0, p_mask;
  logic [CW-1:0] e_cnt = '0;
  logic          e_ovf = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_prev = 0; m_left = 0; m_in_done = 0; e_done = 0;
      e_idx = '0; e_val = '0; e_mask = '0; e_cnt = '0; e_ovf = 0;
    end else begin
      m_allv = &valid_i;
      m_trig = m_allv && !m_prev;
      m_prev = m_allv;
      if (clr_i) begin
        m_left = 0; m_in_done = 0; e_done = 0;
        e_idx = '0; e_val = '0; e_mask = '0; e_cnt = '0; e_ovf = 0;
      end else begin
        m_was_done = m_in_done;
        m_in_done = 0;
        e_done = 0;
        if ((m_left > 0 || m_was_done) && m_trig) e_ovf = 1;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            e_idx = p_idx; e_val = p_val; e_mask = p_mask;
            e_cnt = e_cnt + 1'b1;
            e_done = 1; m_in_done = 1;
          end
        end else if (!m_was_done && m_trig) begin
          p_val = '0; p_idx = '0;
          for (int i = 0; i < NF; i++) begin
            m_v = data_i[i*DW +: DW];
            if (i == 0 || m_v > p_val) begin p_val = m_v; p_idx = IW'(i); end
            p_mask[i] = (m_v >= thr_i);
          end
          m_left = NF;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({done_o, busy_o, peak_idx_o, peak_val_o, hit_mask_o, frame_cnt_o, ovf_o} !==
        {e_done, (m_left > 0 || m_in_done), e_idx, e_val, e_mask, e_cnt, e_ovf}) begin
      n_errors++;
      $display("FAIL cycle_cmp t=%0t got done=%b busy=%b idx=%0d val=%h mask=%h cnt=%0d ovf=%b want done=%b busy=%b idx=%0d val=%h mask=%h cnt=%0d ovf=%b",
               $time, done_o, busy_o, peak_idx_o, peak_val_o, hit_mask_o, frame_cnt_o, ovf_o,
               e_done, (m_left > 0 || m_in_done), e_idx, e_val, e_mask, e_cnt, e_ovf);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Call in the cycle where all-valid was just raised; returns edges counted from the trigger edge.
  task automatic wait_done(input int budget, output int n);
    bit found = 0;
    n = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done_o) found = 1;
    end
    if (!found) chk("done_timeout", 64'(n), 64'hFFFF);
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_o) c++;
    end
  endtask

  task automatic pulse_clr();
    clr_i = 1; step(); clr_i = 0;
  endtask

  int lat, nd;

  initial begin
    step(3);
    rstn = 1;
    step(20);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_cnt", 64'(frame_cnt_o), 64'd0);

    // bins i*10, thr 45
    for (int i = 0; i < NF; i++) data_i[i*DW +: DW] = DW'(i * 10);
    thr_i = 32'd45;
    valid_i = '1;
    wait_done(40, lat);
    chk("latency", 64'(lat), 64'd12);
    chk("ramp_idx", 64'(peak_idx_o), 64'd10);
    chk("ramp_val", 64'(peak_val_o), 64'd100);
    chk("ramp_mask", 64'(hit_mask_o), 64'h7E0);
    chk("ramp_cnt", 64'(frame_cnt_o), 64'd1);
    step(); valid_i = '0; step(2);

    // tie at bins 3 and 7
    for (int i = 0; i < NF; i++) data_i[i*DW +: DW] = 32'd5;
    data_i[3*DW +: DW] = 32'hFFFF_FFFF;
    data_i[7*DW +: DW] = 32'hFFFF_FFFF;
    thr_i = 32'hFFFF_FFFF;
    valid_i = '1;
    wait_done(40, lat);
    chk("tie_idx", 64'(peak_idx_o), 64'd3);
    chk("tie_val", 64'(peak_val_o), 64'hFFFF_FFFF);
    chk("tie_mask", 64'(hit_mask_o), 64'h088);
    step(); valid_i = '0; step(2);

    // overflow: second rising edge 4 cycles after trigger
    pulse_clr();
    step();
    for (int i = 0; i < NF; i++) data_i[i*DW +: DW] = $urandom;
    valid_i = '1;
    step(3);
    valid_i = '0;
    step();
    valid_i = '1;
    count_done(25, nd);
    chk("ovf_one_done", 64'(nd), 64'd1);
    chk("ovf_flag", 64'(ovf_o), 64'd1);
    chk("ovf_cnt", 64'(frame_cnt_o), 64'd1);
    step(); valid_i = '0; step(3);
    valid_i = '1;
    wait_done(40, lat);
    chk("ovf_cnt2", 64'(frame_cnt_o), 64'd2);
    chk("ovf_sticky", 64'(ovf_o), 64'd1);
    step(); valid_i = '0; step(2);

    // clear mid-scan
    valid_i = '1;
    step(5);
    clr_i = 1; thr_i = $urandom;
    step();
    clr_i = 0;
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_ovf", 64'(ovf_o), 64'd0);
    chk("clr_cnt", 64'(frame_cnt_o), 64'd0);
    chk("clr_val", 64'(peak_val_o), 64'd0);
    count_done(20, nd);
    chk("clr_no_done", 64'(nd), 64'd0);
    step(); valid_i = '0; step(2);
    valid_i = '1;
    wait_done(40, lat);
    chk("clr_next_cnt", 64'(frame_cnt_o), 64'd1);
    step(); valid_i = '0; step(2);

    // randomized traffic, checked by the model every cycle
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NF; i++)
        data_i[i*DW +: DW] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 7)) : $urandom;
      thr_i = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7)) : $urandom;
      valid_i = ($urandom_range(0, 4) != 0) ? '1 : NF'($urandom);
      clr_i = ($urandom_range(0, 14) == 0);
      step();
      clr_i = 0;
      for (int k = $urandom_range(1, 16); k > 0; k--) begin
        if ($urandom_range(0, 3) == 0) begin
          data_i[$urandom_range(0, NF-1)*DW +: DW] = $urandom;
          thr_i = $urandom;
        end
        clr_i = ($urandom_range(0, 29) == 0);
        step();
        clr_i = 0;
      end
      valid_i = '0;
      step($urandom_range(1, 3));
    end
    step(15);

    // valid held high for 50 cycles: one frame only
    pulse_clr();
    for (int i = 0; i < NF; i++) data_i[i*DW +: DW] = $urandom;
    valid_i = '1;
    count_done(50, nd);
    chk("held_one_done", 64'(nd), 64'd1);
    chk("held_cnt", 64'(frame_cnt_o), 64'd1);
    step(); valid_i = '0; step(2);

    // async reset mid-scan
    valid_i = '1;
    step(3);
    #3 rstn = 0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_cnt", 64'(frame_cnt_o), 64'd0);
    chk("arst_val", 64'(peak_val_o), 64'd0);
    chk("arst_mask", 64'(hit_mask_o), 64'd0);
    step(3);
    valid_i = '0;
    rstn = 1;
    step(2);
    valid_i = '1;
    wait_done(40, lat);
    chk("arst_next_cnt", 64'(frame_cnt_o), 64'd1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hrz_peak_scan.md
Name: hrz_peak_scan

Overview:
- Downstream consumer of the Goertzel bank's per-bin results (NF bins, DW bits each, per-bin valid).
- On each completed frame it snapshots all bins, sequentially scans them for the peak bin, and builds a threshold hit mask.
- Publishes a stable, frame-counted result set to the register block for SPI readout, with overflow flagging.

Parameters:
- NF, 11, number of frequency bins
- DW, 32, result width per bin (unsigned magnitude/power)
- CW, 16, frame counter width
- IW, 4, peak index width (must satisfy 2^IW >= NF)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- valid_i  in  NF  per-bin result valid from the Goertzel bank (level)
- data_i  in  NF*DW  per-bin results, packed, bin 0 in LSBs
- thr_i  in  DW  hit threshold, unsigned, from register block
- clr_i  in  1  synchronous clear pulse
- busy_o  out  1  high during SCAN and DONE
- done_o  out  1  one-cycle pulse when a new result set is published
- peak_idx_o  out  IW  index of the largest bin
- peak_val_o  out  DW  value of the largest bin
- hit_mask_o  out  NF  bit i set when bin i >= thr_i
- frame_cnt_o  out  CW  number of published frames, wraps
- ovf_o  out  1  sticky flag: a frame was dropped

Behaviour:
- Reset: rstn low asynchronously forces all outputs, snapshot registers, scan registers and the all-valid edge register to 0, and the FSM to IDLE.
- Trigger: all_v = AND of valid_i. trig = all_v & ~all_v_d, where all_v_d is all_v registered. Only a rising edge triggers; a held-high all_v does not retrigger.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On trig, capture data_i into the snapshot array and thr_i into the threshold register on the same edge.
  - Clear the running max to 0, index to 0 and mask to 0, then go to SCAN with bin counter = 0.
- SCAN: processes one bin per cycle for NF cycles, bin 0 first.
  - If snap[i] > running max (strict), then max = snap[i] and idx = i. Ties keep the lower index.
  - Bin 0 always loads: max = snap[0], idx = 0.
  - mask[i] = (snap[i] >= thr), unsigned compare.
  - After bin NF-1 go to DONE.
- DONE: lasts one cycle.
  - done_o = 1.
  - peak_idx_o, peak_val_o and hit_mask_o load from the scan registers.
  - frame_cnt_o increments, wrapping 2^CW-1 -> 0.
  - Next state is IDLE.
- Latency: trig sampled at edge T, SCAN occupies cycles T+1..T+NF, done_o and the new outputs appear at cycle T+NF+1. Total NF+1 cycles, 12 for the defaults.
- Output stability: published outputs hold until the next DONE or clr_i. They never change during SCAN.
- busy_o = 1 in SCAN and DONE, 0 in IDLE.
- Overflow: a trig seen in SCAN or DONE is dropped and sets ovf_o. ovf_o is sticky and is cleared only by clr_i or reset.
- clr_i, synchronous, highest priority:
  - Next state IDLE; any scan in progress is aborted with no done_o.
  - Zeroes all published outputs, frame_cnt_o and ovf_o.
  - all_v_d still updates on this edge.
- clr_i and trig in the same cycle: trig is ignored, no capture and no ovf.
- thr_i changes mid-scan have no effect because the threshold is latched at trigger.
- data_i changes after the trigger edge have no effect because the snapshot is used.
- valid_i falling mid-scan has no effect; the next frame needs a fresh rising edge of all_v.
- Partial valid (some bits low) gives no trigger.

Test Plan:
- Reset then idle, 20 cycles with no valid: all outputs 0, busy_o = 0, no done_o.
- Bins = i*10 (bin i), thr = 45, all valid_i rise at T: done_o only at T+12; peak_idx_o = 10; peak_val_o = 100; hit_mask_o = 0x7E0; frame_cnt_o = 1.
- Tie case, bins 3 and 7 = 0xFFFF_FFFF and others 5, thr = 0xFFFF_FFFF: peak_idx_o = 3; peak_val_o = 0xFFFF_FFFF; hit_mask_o = 0x088.
- Second all-valid rising edge 4 cycles after the first trigger: dropped; ovf_o = 1 and stays 1; only one done_o; frame_cnt_o = 1. A further frame after idle publishes with frame_cnt_o = 2.
- clr_i pulsed at T+5 mid-scan: no done_o; all outputs and ovf_o = 0; busy_o = 0 from T+6. A new trigger then completes normally with frame_cnt_o = 1.
- valid_i held high for 50 cycles after the trigger: exactly one done_o. rstn asserted mid-scan forces outputs to 0 immediately without waiting for a clock edge.
